// File: rtl/opmux_stage.sv
// opmux_stage: selects ALU operands A/B from NSRC packed sources into a registered
// valid/ready stage. Define OPMUX_SKID_EN to add a skid entry that cuts the out_ready -> in_ready path.
module opmux_stage #(
    parameter int XLEN  = 32,
    parameter int NSRC  = 4,
    parameter int SELW  = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NSRC*XLEN-1:0] src_data,
    input  logic [SELW-1:0]      sel_a,
    input  logic [SELW-1:0]      sel_b,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [XLEN-1:0]      op_a,
    output logic [XLEN-1:0]      op_b,
    output logic                 sel_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     xfer_cnt
);
    localparam logic [SELW:0] NSRC_LIM = (SELW+1)'(NSRC);

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic            err;
    } entry_t;

    localparam entry_t ENTRY_ZERO = {$bits(entry_t){1'b0}};

    function automatic logic sel_in_range(input logic [SELW-1:0] sel);
        return ({1'b0, sel} < NSRC_LIM);
    endfunction

    // Out-of-range selects match no source and fall through to zero.
    function automatic logic [XLEN-1:0] pick_src(input logic [NSRC*XLEN-1:0] src,
                                                 input logic [SELW-1:0]      sel);
        logic [XLEN-1:0] val;
        val = {XLEN{1'b0}};
        for (int k = 0; k < NSRC; k++) begin
            val = (sel == SELW'(k)) ? src[k*XLEN +: XLEN] : val;
        end
        return val;
    endfunction

    entry_t           cap_s;
    entry_t           main_r;
    logic             main_valid_r;
    logic [CNT_W-1:0] cnt_r;
    logic             accept_s;
    logic             xfer_s;

    // Candidate entry built from the current selects and sources.
    always_comb begin
        cap_s     = ENTRY_ZERO;
        cap_s.a   = pick_src(src_data, sel_a);
        cap_s.b   = pick_src(src_data, sel_b);
        cap_s.err = !sel_in_range(sel_a) || !sel_in_range(sel_b);
    end

    assign accept_s = in_valid && in_ready && !flush;
    assign xfer_s   = main_valid_r && out_ready && !flush;

`ifdef OPMUX_SKID_EN
    entry_t skid_r;
    logic   skid_valid_r;
    logic   main_free_s;

    assign in_ready    = !skid_valid_r;
    assign main_free_s = !main_valid_r || xfer_s;

    // Main/skid pair: skid refills main on transfer, catches an accept while main is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_r       <= ENTRY_ZERO;
            main_valid_r <= 1'b0;
            skid_r       <= ENTRY_ZERO;
            skid_valid_r <= 1'b0;
        end else if (flush) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (main_free_s) begin
            if (skid_valid_r) begin
                main_r       <= skid_r;
                main_valid_r <= 1'b1;
                skid_valid_r <= 1'b0;
            end else if (accept_s) begin
                main_r       <= cap_s;
                main_valid_r <= 1'b1;
            end else begin
                main_valid_r <= 1'b0;
            end
        end else if (accept_s) begin
            skid_r       <= cap_s;
            skid_valid_r <= 1'b1;
        end else begin
            skid_valid_r <= skid_valid_r;
        end
    end
`else
    assign in_ready = !main_valid_r || out_ready;

    // Single output register: load on accept, drain on transfer, clear on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_r       <= ENTRY_ZERO;
            main_valid_r <= 1'b0;
        end else if (flush) begin
            main_valid_r <= 1'b0;
        end else if (accept_s) begin
            main_r       <= cap_s;
            main_valid_r <= 1'b1;
        end else if (xfer_s) begin
            main_valid_r <= 1'b0;
        end else begin
            main_valid_r <= main_valid_r;
        end
    end
`endif

    // Transfer counter; a flush-cancelled transfer is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (xfer_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign op_a      = main_r.a;
    assign op_b      = main_r.b;
    assign sel_err   = main_r.err;
    assign out_valid = main_valid_r;
    assign xfer_cnt  = cnt_r;

endmodule

// File: tb/tb_opmux_stage.sv
// Directed self-checking bench for opmux_stage: a 4-source and a 3-source instance share stimulus.
module tb_opmux_stage;
    localparam int XLEN = 32;
`ifdef OPMUX_SKID_EN
    localparam int SKID = 1;
`else
    localparam int SKID = 0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [4*XLEN-1:0] src_data;
    logic [1:0]      sel_a, sel_b;
    logic            in_valid, flush, out_ready;

    logic            in_ready0, sel_err0, out_valid0;
    logic [XLEN-1:0] op_a0, op_b0;
    logic [7:0]      xfer_cnt0;
    logic            in_ready1, sel_err1, out_valid1;
    logic [XLEN-1:0] op_a1, op_b1;
    logic [7:0]      xfer_cnt1;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    int n_acc;
    logic acc;

    always #5 clk = ~clk;

    opmux_stage #(.XLEN(XLEN), .NSRC(4), .SELW(2), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .src_data(src_data), .sel_a(sel_a), .sel_b(sel_b),
        .in_valid(in_valid), .in_ready(in_ready0), .flush(flush), .op_a(op_a0), .op_b(op_b0),
        .sel_err(sel_err0), .out_valid(out_valid0), .out_ready(out_ready), .xfer_cnt(xfer_cnt0)
    );

    opmux_stage #(.XLEN(XLEN), .NSRC(3), .SELW(2), .CNT_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .src_data(src_data[3*XLEN-1:0]), .sel_a(sel_a), .sel_b(sel_b),
        .in_valid(in_valid), .in_ready(in_ready1), .flush(flush), .op_a(op_a1), .op_b(op_b1),
        .sel_err(sel_err1), .out_valid(out_valid1), .out_ready(out_ready), .xfer_cnt(xfer_cnt1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int tv_sa [3] = '{0, 2, 3};
    int tv_sb [3] = '{1, 2, 0};
    int tv_ea [3] = '{10, 30, 40};
    int tv_eb [3] = '{20, 30, 10};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        sel_a = 2'd0; sel_b = 2'd0;
        src_data = {32'd40, 32'd30, 32'd20, 32'd10};
        repeat (2) tick();
        check_eq("rst_op_a", op_a0, 0);
        check_eq("rst_op_b", op_b0, 0);
        check_eq("rst_sel_err", sel_err0, 0);
        check_eq("rst_out_valid", out_valid0, 0);
        check_eq("rst_xfer_cnt", xfer_cnt0, 0);
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_in_ready", in_ready0, 1);

        // Basic selects, including sel_a == sel_b.
        for (int i = 0; i < 3; i++) begin
            sel_a = tv_sa[i][1:0]; sel_b = tv_sb[i][1:0];
            in_valid = 1'b1; out_ready = 1'b1;
            tick();
            check_eq("vec_op_a", op_a0, 64'(tv_ea[i]));
            check_eq("vec_op_b", op_b0, 64'(tv_eb[i]));
            check_eq("vec_out_valid", out_valid0, 1);
            check_eq("vec_sel_err", sel_err0, 0);
            check_eq("vec_cnt_before", xfer_cnt0, 64'(exp_cnt));
            in_valid = 1'b0;
            tick();
            exp_cnt++;
            check_eq("vec_cnt_after", xfer_cnt0, 64'(exp_cnt));
            check_eq("vec_drained", out_valid0, 0);
        end

        // Out-of-range select on the 3-source instance.
        sel_a = 2'd0; sel_b = 2'd3; in_valid = 1'b1;
        tick();
        check_eq("oor_op_a", op_a1, 10);
        check_eq("oor_op_b", op_b1, 0);
        check_eq("oor_sel_err", sel_err1, 1);
        check_eq("inrange_op_b", op_b0, 40);
        check_eq("inrange_sel_err", sel_err0, 0);
        in_valid = 1'b0;
        tick();
        exp_cnt++;

        // Stall: E1 held while E2 is offered for five cycles.
        sel_a = 2'd0; sel_b = 2'd1; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        sel_a = 2'd2; sel_b = 2'd3; n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            acc = in_valid && in_ready0;
            tick();
            if (acc) begin
                in_valid = 1'b0;
                n_acc++;
            end
            check_eq("stall_op_a", op_a0, 10);
            check_eq("stall_op_b", op_b0, 20);
            check_eq("stall_out_valid", out_valid0, 1);
            check_eq("stall_in_ready", in_ready0, 0);
        end
        check_eq("stall_extra_accepts", n_acc, SKID);
        out_ready = 1'b1;
        @(negedge clk);
        acc = in_valid && in_ready0;
        tick();
        if (acc) in_valid = 1'b0;
        exp_cnt++;
        check_eq("release_op_a", op_a0, 30);
        check_eq("release_op_b", op_b0, 40);
        check_eq("release_out_valid", out_valid0, 1);
        check_eq("release_cnt", xfer_cnt0, 64'(exp_cnt));
        tick();
        exp_cnt++;
        check_eq("release_drained", out_valid0, 0);
        check_eq("release_cnt2", xfer_cnt0, 64'(exp_cnt));

        // Flush beats both a same-cycle capture and a same-cycle transfer.
        sel_a = 2'd0; sel_b = 2'd1; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        check_eq("pre_flush_valid", out_valid0, 1);
        sel_a = 2'd1; sel_b = 2'd0; out_ready = 1'b1; flush = 1'b1;
        tick();
        check_eq("flush_out_valid", out_valid0, 0);
        check_eq("flush_cnt", xfer_cnt0, 64'(exp_cnt));
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check_eq("flush_no_ghost", out_valid0, 0);
        check_eq("flush_cnt2", xfer_cnt0, 64'(exp_cnt));

        // Reset mid-stall with everything full.
        sel_a = 2'd0; sel_b = 2'd1; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        sel_a = 2'd2; sel_b = 2'd3;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid0, 0);
        check_eq("midrst_op_a", op_a0, 0);
        check_eq("midrst_cnt", xfer_cnt0, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("midrst_in_ready", in_ready0, 1);
        check_eq("midrst_still_empty", out_valid0, 0);

        // 257 transfers: counter wraps 255 -> 0 -> 1.
        sel_a = 2'd0; sel_b = 2'd1; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 257; i++) begin
            tick();
            if (i == 256) check_eq("wrap_cnt_255", xfer_cnt0, 255);
            if (i == 257) check_eq("wrap_cnt_0", xfer_cnt0, 0);
        end
        in_valid = 1'b0;
        tick();
        check_eq("wrap_cnt_1", xfer_cnt0, 1);
        check_eq("wrap_cnt_1_u1", xfer_cnt1, 1);
        check_eq("wrap_drained", out_valid0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
